// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a byte FIFO feeding an 8N1 (optionally 8E1) serializer.
// Bytes leave LSB first. Back-to-back frames have no idle gap while the FIFO holds data.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [7:0]                          tx_data_i,
  input  logic                                tx_valid_i,
  output logic                                tx_ready_o,
  output logic                                uart_tx_o,
  output logic                                uart_busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [7:0]    rd_data_reg;

  logic [2:0]    state_reg;
  logic [CW-1:0] baud_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic          tx_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic baud_done;

  assign full      = (level_reg == LEVEL_FULL);
  assign empty     = (level_reg == '0);
  assign push      = tx_valid_i & ~full;
  assign baud_done = (baud_reg == BAUD_LAST);
  assign pop       = ~empty & ((state_reg == IDLE) | ((state_reg == STOP) & baud_done));

  // Storage and registered read; the popped byte is only needed once START ends.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= tx_data_i;
    if (pop)  rd_data_reg     <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // The line value is registered alongside each state change so uart_tx_o is glitch-free.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      tx_reg      <= 1'b1;
    end else begin
      baud_reg <= baud_done ? '0 : baud_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          baud_reg <= '0;
          tx_reg   <= 1'b1;
          if (pop) begin
            state_reg <= START;
            tx_reg    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            state_reg   <= DATA;
            bit_idx_reg <= '0;
            shift_reg   <= {1'b0, rd_data_reg[7:1]};
            parity_reg  <= ^rd_data_reg;
            tx_reg      <= rd_data_reg[0];
          end
        end
        DATA: begin
          if (baud_done) begin
            if (bit_idx_reg == 3'd7) begin
              if (PARITY_EN != 0) begin
                state_reg <= PARITY;
                tx_reg    <= parity_reg;
              end else begin
                state_reg <= STOP;
                tx_reg    <= 1'b1;
              end
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              tx_reg      <= shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[7:1]};
            end
          end
        end
        PARITY: begin
          if (baud_done) begin
            state_reg <= STOP;
            tx_reg    <= 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            if (pop) begin
              state_reg <= START;
              tx_reg    <= 1'b0;
            end else begin
              state_reg <= IDLE;
              tx_reg    <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready_o   = ~full;
  assign uart_tx_o    = tx_reg;
  assign uart_busy_o  = (state_reg != IDLE) | ~empty;
  assign fifo_level_o = level_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: two instances (no parity / even parity), a line
// decoder per instance pops expected bytes from a queue filled by the push driver.
module tb_uart_tx_fifo;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic       ready0, ready1, tx0, tx1, busy0, busy1;
  logic [2:0] level0, level1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int contig[2] = '{0, 0};
  int since[2] = '{0, 0};
  int last_start[2] = '{-1, -1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_EN(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(valid0),
    .tx_ready_o(ready0), .uart_tx_o(tx0), .uart_busy_o(busy0), .fifo_level_o(level0));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_EN(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(valid1),
    .tx_ready_o(ready1), .uart_tx_o(tx1), .uart_busy_o(busy1), .fifo_level_o(level1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic line_of(input int id);
    return (id == 0) ? tx0 : tx1;
  endfunction

  // Decode one frame per start bit; every bit must hold for exactly CPB samples.
  task automatic monitor(input int id);
    logic samp[44];
    logic [7:0] got, exp;
    logic stable, aborted;
    int nbits, start_cyc;
    forever begin
      @(negedge clk);
      if (rst || line_of(id)) continue;
      start_cyc = cyc;
      aborted = 1'b0;
      nbits = (id == 0) ? 10 : 11;
      for (int s = 0; s < nbits * CPB; s++) begin
        if (s != 0) @(negedge clk);
        if (rst) begin
          aborted = 1'b1;
          break;
        end
        samp[s] = line_of(id);
      end
      if (aborted) continue;
      stable = 1'b1;
      for (int b = 0; b < nbits; b++)
        for (int j = 1; j < CPB; j++)
          if (samp[b*CPB+j] !== samp[b*CPB]) stable = 1'b0;
      for (int i = 0; i < 8; i++) got[i] = samp[(1+i)*CPB];
      check("frame_shape", {stable, samp[(nbits-1)*CPB]}, 2'b11);
      if ((id == 0 && exp0.size() == 0) || (id == 1 && exp1.size() == 0)) begin
        check("unexpected_frame", {24'h0, got}, 32'hFFFF_FFFF);
      end else begin
        exp = (id == 0) ? exp0.pop_front() : exp1.pop_front();
        check("frame_data", got, exp);
        if (id == 1) check("parity_bit", samp[9*CPB], ^exp);
      end
      if (contig[id] != 0 && last_start[id] >= since[id])
        check("frame_gap", start_cyc - last_start[id], (id == 0) ? 10*CPB : 11*CPB);
      last_start[id] = start_cyc;
      $display("dut%0d frame byte=%02h start_cycle=%0d", id, got, start_cyc);
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // Called at a negedge; returns at the negedge after the accepting edge, k = that edge.
  task automatic push(input int id, input logic [7:0] d, output int k);
    int g = 0;
    tx_data = d;
    if (id == 0) valid0 = 1'b1; else valid1 = 1'b1;
    while (!((id == 0) ? ready0 : ready1) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      check("push_timeout", 0, 1);
      valid0 = 1'b0;
      valid1 = 1'b0;
      k = cyc;
      return;
    end
    if (id == 0) exp0.push_back(d); else exp1.push_back(d);
    @(negedge clk);
    k = cyc;
  endtask

  task automatic wait_idle(input int id);
    int g = 0;
    while (((id == 0) ? busy0 : busy1) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) check("idle_timeout", 0, 1);
  endtask

  task automatic contig_on(input int id);
    contig[id] = 1;
    since[id] = cyc;
  endtask

  initial begin
    int k, k0, cnt, bad;
    repeat (3) @(negedge clk);
    check("rst_tx", tx0, 1);
    check("rst_busy", busy0, 0);
    check("rst_ready", ready0, 1);
    check("rst_level", level0, 0);
    check("rst_tx_p", tx1, 1);
    #2 rst = 1'b0;
    @(negedge clk);

    // Quiet line after reset
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || ready0 !== 1'b1) bad++;
      if (tx1 !== 1'b1 || busy1 !== 1'b0 || ready1 !== 1'b1) bad++;
      @(negedge clk);
    end
    check("idle_line", bad, 0);

    // Single byte, latency and busy duration
    push(0, 8'h55, k);
    valid0 = 1'b0;
    check("lat_tx_high", tx0, 1);
    check("lat_level", level0, 1);
    check("lat_busy", busy0, 1);
    cnt = 1;
    @(negedge clk);
    check("lat_start_low", tx0, 0);
    check("lat_level_pop", level0, 0);
    while (busy0 && cnt < 500) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", cnt, 41);

    // Parity frames back to back
    contig_on(1);
    push(1, 8'h55, k);
    push(1, 8'h07, k);
    valid1 = 1'b0;
    wait_idle(1);
    contig[1] = 0;

    // Fill to full with valid held high
    contig_on(0);
    for (int i = 0; i < 6; i++) begin
      push(0, 8'hB0 + 8'(i), k);
      if (i == 0) k0 = k;
      if (i == 4) begin
        check("full_ready", ready0, 0);
        check("full_level", level0, 4);
      end
      if (i == 5) check("sixth_accept_edge", k - k0, 42);
    end
    valid0 = 1'b0;
    wait_idle(0);

    // Push coinciding with pop at level 2
    contig_on(0);
    push(0, 8'hC0, k0);
    push(0, 8'hC1, k);
    push(0, 8'hC2, k);
    valid0 = 1'b0;
    check("level_two", level0, 2);
    while (cyc < k0 + 40) @(negedge clk);
    check("level_before_pushpop", level0, 2);
    push(0, 8'hC3, k);
    valid0 = 1'b0;
    check("pushpop_edge", k - k0, 41);
    check("pushpop_level", level0, 2);
    wait_idle(0);

    // Ordering across pointer wrap
    contig_on(0);
    for (int i = 0; i < 16; i++) push(0, 8'(i), k);
    valid0 = 1'b0;
    wait_idle(0);
    contig[0] = 0;

    // Reset in the middle of a frame with bytes queued
    push(0, 8'hA3, k0);
    for (int i = 1; i < 4; i++) push(0, 8'(i), k);
    valid0 = 1'b0;
    check("queued_three", level0, 3);
    while (cyc < k0 + 12) @(negedge clk);
    #2 rst = 1'b1;
    exp0.delete();
    #1;
    check("mid_rst_tx", tx0, 1);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_level", level0, 0);
    check("mid_rst_ready", ready0, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    push(0, 8'h3C, k);
    valid0 = 1'b0;
    wait_idle(0);
    repeat (60) @(negedge clk);
    check("post_rst_busy", busy0, 0);
    check("sb0_empty", exp0.size(), 0);
    check("sb1_empty", exp1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
